// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the panel RESX reset sequencer.
// Holds the state encoding, handshake timeout and pin level names.
package pkg_ili9341;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Cycles allowed in WAIT_DONE for reset_init to report completion.
  localparam int DONE_TO_CYC = 4;

  typedef enum logic [3:0] {
    IDLE,
    ARM,
    PH_H1,
    PH_L,
    PH_H2,
    WAIT_DONE,
    SETTLE,
    READY,
    ERROR
  } seq_state_t;

  function automatic logic is_phase(seq_state_t s);
    return (s == PH_H1) || (s == PH_L) || (s == PH_H2);
  endfunction

  function automatic logic is_busy(seq_state_t s);
    return is_phase(s) || (s == ARM) || (s == WAIT_DONE) || (s == SETTLE);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the reset_init
// pin driver (slave).
interface reset_sequencer_if;
  logic reset_ena;
  logic reset_val;
  logic resets_sent;
  logic reset_init_ena;
  logic reset_sent;

  modport master (
    input  reset_ena, reset_val, resets_sent,
    output reset_init_ena, reset_sent
  );

  modport slave (
    output reset_ena, reset_val, resets_sent,
    input  reset_init_ena, reset_sent
  );
endinterface

// File: rtl/reset_sequencer_core.sv
// Sequencer FSM: drives the three RESX phases through reset_init,
// waits for completion, settles, and flags handshake failures.
module reset_sequencer_core
  import pkg_ili9341::*;
#(
  parameter int T_H1_CYC     = 1000,
  parameter int T_L_CYC      = 1000,
  parameter int T_H2_CYC     = 500000,
  parameter int T_SETTLE_CYC = 12000000,
  parameter int CW           = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  reset_sequencer_if.master   rif,
  output logic                o_lcd_rst,
  output logic                o_busy,
  output logic                o_ready,
  output logic                o_err
);

  localparam logic [CW-1:0] LD_H1     = CW'(T_H1_CYC - 1);
  localparam logic [CW-1:0] LD_L      = CW'(T_L_CYC - 1);
  localparam logic [CW-1:0] LD_H2     = CW'(T_H2_CYC - 1);
  localparam logic [CW-1:0] LD_DONE   = CW'(DONE_TO_CYC - 1);
  localparam logic [CW-1:0] LD_SETTLE = CW'(T_SETTLE_CYC - 1);

  seq_state_t    r_state;
  seq_state_t    w_state_next;
  logic          w_tmr_load;
  logic          w_tmr_dec;
  logic [CW-1:0] w_tmr_val;
  logic          w_tmr_zero;

  phase_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_dec      (w_tmr_dec),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_dec    = 1'b0;
    w_tmr_val    = '0;
    case (r_state)
      IDLE, READY, ERROR: begin
        if (i_start) w_state_next = ARM;
      end
      ARM: begin
        w_tmr_load   = 1'b1;
        w_tmr_val    = LD_H1;
        w_state_next = PH_H1;
      end
      PH_H1, PH_L, PH_H2: begin
        // Losing reset_ena mid-phase means reset_init dropped the sequence.
        if (!rif.reset_ena) begin
          w_state_next = ERROR;
        end else if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          if (r_state == PH_H1) begin
            w_tmr_val    = LD_L;
            w_state_next = PH_L;
          end else if (r_state == PH_L) begin
            w_tmr_val    = LD_H2;
            w_state_next = PH_H2;
          end else begin
            w_tmr_val    = LD_DONE;
            w_state_next = WAIT_DONE;
          end
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (rif.resets_sent) begin
          w_tmr_load   = 1'b1;
          w_tmr_val    = LD_SETTLE;
          w_state_next = SETTLE;
        end else if (w_tmr_zero) begin
          w_state_next = ERROR;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      SETTLE: begin
        if (w_tmr_zero) w_state_next = READY;
        else            w_tmr_dec    = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign rif.reset_init_ena = (r_state == ARM);
  assign rif.reset_sent     = is_phase(r_state) && w_tmr_zero && rif.reset_ena;
  assign o_busy             = is_busy(r_state);
  assign o_ready            = (r_state == READY);
  assign o_err              = (r_state == ERROR);
  assign o_lcd_rst          = rif.reset_ena ? rif.reset_val : HIGH;

endmodule

// File: rtl/reset_sequencer_phase_timer.sv
// Loadable CW-bit down-counter with a zero flag, shared by all timed
// states of the reset sequencer.
module phase_timer #(
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_dec,
  input  logic [CW-1:0] i_load_val,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Panel reset sequencer top: bundles the reset_init pins into the
// handshake interface and hosts the sequencer core.
module reset_sequencer
  import pkg_ili9341::*;
#(
  parameter int T_H1_CYC     = 1000,
  parameter int T_L_CYC      = 1000,
  parameter int T_H2_CYC     = 500000,
  parameter int T_SETTLE_CYC = 12000000,
  parameter int CW           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_reset_ena,
  input  logic i_reset_val,
  input  logic i_resets_sent,
  output logic o_reset_init_ena,
  output logic o_reset_sent,
  output logic o_lcd_rst,
  output logic o_busy,
  output logic o_ready,
  output logic o_err
);

  reset_sequencer_if w_rif ();

  assign w_rif.reset_ena   = i_reset_ena;
  assign w_rif.reset_val   = i_reset_val;
  assign w_rif.resets_sent = i_resets_sent;
  assign o_reset_init_ena  = w_rif.reset_init_ena;
  assign o_reset_sent      = w_rif.reset_sent;

  reset_sequencer_core #(
    .T_H1_CYC     (T_H1_CYC),
    .T_L_CYC      (T_L_CYC),
    .T_H2_CYC     (T_H2_CYC),
    .T_SETTLE_CYC (T_SETTLE_CYC),
    .CW           (CW)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .rif       (w_rif),
    .o_lcd_rst (o_lcd_rst),
    .o_busy    (o_busy),
    .o_ready   (o_ready),
    .o_err     (o_err)
  );

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a reset_init model on the handshake bus,
// an event-timeline reference model feeding a scoreboard, and a monitor.
module tb_reset_sequencer;

  localparam int T1 = 3;
  localparam int TL = 4;
  localparam int T2 = 5;
  localparam int TS = 6;
  localparam int TO = 4;
  localparam int NSEQ = 15;

  typedef enum int {
    EV_INIT, EV_SENT, EV_BUSY_RISE, EV_BUSY_FALL, EV_READY_RISE,
    EV_READY_FALL, EV_ERR_RISE, EV_ERR_FALL, EV_LCD_RISE, EV_LCD_FALL
  } ev_kind_t;

  typedef struct {
    int       cyc;
    ev_kind_t kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic o_lcd_rst, o_busy, o_ready, o_err;
  logic abort_ena = 1'b0;
  logic block_sent = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];

  reset_sequencer_if u_if ();

  reset_sequencer #(
    .T_H1_CYC(T1), .T_L_CYC(TL), .T_H2_CYC(T2), .T_SETTLE_CYC(TS), .CW(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_reset_ena      (u_if.reset_ena),
    .i_reset_val      (u_if.reset_val),
    .i_resets_sent    (u_if.resets_sent),
    .o_reset_init_ena (u_if.reset_init_ena),
    .o_reset_sent     (u_if.reset_sent),
    .o_lcd_rst        (o_lcd_rst),
    .o_busy           (o_busy),
    .o_ready          (o_ready),
    .o_err            (o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reset_init model: H, then L, then H, one level per phase pulse.
  logic ri_ena, ri_val, ri_done;
  int   ri_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ri_ena <= 1'b0; ri_val <= 1'b1; ri_done <= 1'b0; ri_cnt <= 0;
    end else if (u_if.reset_init_ena) begin
      ri_ena <= 1'b1; ri_val <= 1'b1; ri_done <= 1'b0; ri_cnt <= 0;
    end else if (abort_ena) begin
      ri_ena <= 1'b0;
    end else if (u_if.reset_sent && ri_ena) begin
      if (ri_cnt == 2) begin
        ri_ena <= 1'b0; ri_val <= 1'b1; ri_done <= 1'b1;
      end else begin
        ri_val <= ~ri_val; ri_cnt <= ri_cnt + 1;
      end
    end
  end
  assign u_if.reset_ena   = ri_ena;
  assign u_if.reset_val   = ri_val;
  assign u_if.resets_sent = ri_done & ~block_sent;

  function automatic void push_ev(int c, ev_kind_t k);
    ev_t e;
    int  i;
    e.cyc  = c;
    e.kind = k;
    i = exp_q.size();
    while (i > 0 && (exp_q[i-1].cyc > c || (exp_q[i-1].cyc == c && exp_q[i-1].kind > k)))
      i--;
    exp_q.insert(i, e);
  endfunction

  function automatic void add_cut(int c, ev_kind_t k, int cut);
    if (c <= cut) push_ev(c, k);
  endfunction

  task automatic check_ev(ev_kind_t k);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: got %s at cycle %0d, required no event", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                 k.name(), cyc, e.kind.name(), e.cyc);
      end
    end
  endtask

  task automatic chk(string name, logic got, logic expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, got, expv);
    end
  endtask

  task automatic wait_neg(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: turns output pulses and level edges into events for the scoreboard.
  initial begin
    logic p_busy, p_ready, p_err, p_lcd;
    ev_t  e;
    p_busy = 1'b0; p_ready = 1'b0; p_err = 1'b0; p_lcd = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL event: got nothing by cycle %0d, required %s at cycle %0d",
                 cyc, e.kind.name(), e.cyc);
      end
      if (u_if.reset_init_ena === 1'b1) check_ev(EV_INIT);
      if (u_if.reset_sent === 1'b1)     check_ev(EV_SENT);
      if (o_busy === 1'b1 && !p_busy)   check_ev(EV_BUSY_RISE);
      if (o_busy === 1'b0 && p_busy)    check_ev(EV_BUSY_FALL);
      if (o_ready === 1'b1 && !p_ready) check_ev(EV_READY_RISE);
      if (o_ready === 1'b0 && p_ready)  check_ev(EV_READY_FALL);
      if (o_err === 1'b1 && !p_err)     check_ev(EV_ERR_RISE);
      if (o_err === 1'b0 && p_err)      check_ev(EV_ERR_FALL);
      if (o_lcd_rst === 1'b1 && !p_lcd) check_ev(EV_LCD_RISE);
      if (o_lcd_rst === 1'b0 && p_lcd)  check_ev(EV_LCD_FALL);
      p_busy = o_busy; p_ready = o_ready; p_err = o_err; p_lcd = o_lcd_rst;
    end
  end

  initial begin
    int status;      // 0 idle, 1 ready, 2 error
    int next_free;
    int s, a, e3, wd, k, rdy, cut, scen;
    string sname;
    ev_t e;

    @(posedge clk);
    #3;
    chk("reset_init_ena", u_if.reset_init_ena, 1'b0);
    chk("reset_sent", u_if.reset_sent, 1'b0);
    chk("busy", o_busy, 1'b0);
    chk("ready", o_ready, 1'b0);
    chk("err", o_err, 1'b0);
    chk("lcd_rst", o_lcd_rst, 1'b1);
    wait_neg(3);
    rst = 1'b0;

    status = 0;
    next_free = 5;
    for (int i = 0; i < NSEQ; i++) begin
      scen = i % 5;
      s    = next_free + int'($urandom_range(0, 3));
      a    = s + 1;
      e3   = a + T1 + TL + T2;
      wd   = e3 + 1;
      rdy  = wd + 1 + TS;
      k    = a + T1 + int'($urandom_range(1, TL));
      cut  = (scen >= 3) ? k : 1000000;
      case (scen)
        0: sname = "nominal";
        1: sname = "start held";
        2: sname = "done timeout";
        3: sname = "lost handshake";
        default: sname = "reset mid-phase";
      endcase

      wait_neg(s);
      block_sent = (scen == 2);
      i_start = 1'b1;

      push_ev(a, EV_INIT);
      push_ev(a, EV_BUSY_RISE);
      if (status == 1) push_ev(a, EV_READY_FALL);
      if (status == 2) push_ev(a, EV_ERR_FALL);
      add_cut(a + T1, EV_SENT, cut);
      add_cut(a + T1 + 1, EV_LCD_FALL, cut);
      add_cut(a + T1 + TL, EV_SENT, cut);
      add_cut(a + T1 + TL + 1, EV_LCD_RISE, cut);
      add_cut(e3, EV_SENT, cut);
      case (scen)
        0, 1: begin
          push_ev(rdy, EV_READY_RISE); push_ev(rdy, EV_BUSY_FALL);
          status = 1; next_free = rdy + 2;
        end
        2: begin
          push_ev(wd + TO, EV_ERR_RISE); push_ev(wd + TO, EV_BUSY_FALL);
          status = 2; next_free = wd + TO + 2;
        end
        3: begin
          push_ev(k + 1, EV_LCD_RISE);
          push_ev(k + 2, EV_ERR_RISE); push_ev(k + 2, EV_BUSY_FALL);
          status = 2; next_free = k + 4;
        end
        default: begin
          push_ev(k + 1, EV_LCD_RISE); push_ev(k + 1, EV_BUSY_FALL);
          status = 0; next_free = k + 3;
        end
      endcase
      $display("seq %0d: %s, start cycle %0d, event cycle %0d", i, sname, s, k);

      if (scen == 1) wait_neg(rdy - 1);
      else           wait_neg(s + 1);
      i_start = 1'b0;
      if (scen == 3) begin
        wait_neg(k);     abort_ena = 1'b1;
        wait_neg(k + 1); abort_ena = 1'b0;
      end else if (scen == 4) begin
        wait_neg(k);     rst = 1'b1;
        wait_neg(k + 1); rst = 1'b0;
      end
    end

    wait_neg(next_free + 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL event: got nothing, required %s at cycle %0d", e.kind.name(), e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
